// File: rtl/seq_1101_frame_tx_if.sv
// Handshake and serial-line bundle for the 1101 frame transmitter.
// The master offers payload words; the slave (transmitter) drives the line.
interface seq_1101_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_active;
  logic              frame_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, tx_bit, tx_active, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, tx_bit, tx_active, frame_done
  );
endinterface

// File: rtl/seq_1101_frame_tx.sv
// Serial frame transmitter: 1101 preamble, MSB-first payload, even parity, one idle gap bit.
// The first bit is on the line the cycle after the handshake; one word is accepted per frame while idle.
module seq_1101_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  seq_1101_frame_tx_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] PAR  = 3'd3;
  localparam logic [2:0] GAP  = 3'd4;

  localparam int IDX_N = (DATA_W > 4) ? DATA_W : 4;
  localparam int IDX_W = $clog2(IDX_N);
  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(3);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  // Preamble bit k sits at PRE_PAT[k]: line order 1,1,0,1.
  localparam logic [3:0]       PRE_PAT   = 4'b1011;

  logic [2:0]        state;
  logic [CYC_W-1:0]  cyc;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              parity;
  logic              tx_bit_q;
  logic              tx_active_q;
  logic              frame_done_q;
  logic              bit_end;

  assign bit_end        = (cyc == CYC_LAST);
  assign bus.in_ready   = (state == IDLE) & ~rst;
  assign bus.tx_bit     = tx_bit_q;
  assign bus.tx_active  = tx_active_q;
  assign bus.frame_done = frame_done_q;

  // State and counters describe the bit currently on the line; tx_bit is
  // loaded with the next bit's value at the edge that starts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cyc          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      parity       <= 1'b0;
      tx_bit_q     <= 1'b0;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (state != IDLE) begin
        cyc <= bit_end ? '0 : cyc + CYC_W'(1);
      end
      case (state)
        IDLE: begin
          cyc <= '0;
          if (bus.in_valid && bus.in_ready) begin
            state       <= PRE;
            bit_idx     <= '0;
            shreg       <= bus.in_data;
            parity      <= ^bus.in_data;
            tx_bit_q    <= PRE_PAT[0];
            tx_active_q <= 1'b1;
          end
        end
        PRE: begin
          if (bit_end) begin
            if (bit_idx == PRE_LAST) begin
              state    <= DATA;
              bit_idx  <= '0;
              tx_bit_q <= shreg[DATA_W-1];
              shreg    <= shreg << 1;
            end else begin
              bit_idx  <= bit_idx + IDX_W'(1);
              tx_bit_q <= PRE_PAT[bit_idx[1:0] + 2'd1];
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == DATA_LAST) begin
              state    <= PAR;
              bit_idx  <= '0;
              tx_bit_q <= parity;
            end else begin
              bit_idx  <= bit_idx + IDX_W'(1);
              tx_bit_q <= shreg[DATA_W-1];
              shreg    <= shreg << 1;
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            state    <= GAP;
            tx_bit_q <= 1'b0;
          end
        end
        GAP: begin
          if (bit_end) begin
            state        <= IDLE;
            tx_active_q  <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          tx_bit_q    <= 1'b0;
          tx_active_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/seq_1101_frame_tx.md
# seq_1101_frame_tx

Serial frame transmitter that produces the bitstream consumed by the team's non-overlapping 1101 Moore sequence detector. It accepts one DATA_W-bit word per frame through a valid/ready handshake. It emits a fixed 1101 preamble, the payload MSB-first, an even-parity bit and one idle gap bit, one bit per BIT_CYCLES clocks. It sits at the transmit end of the serial link and drives the detector's `data` input directly.

## Interface

- DATA_W, 8: payload width in bits, ≥1.
- BIT_CYCLES, 1: clock cycles each serial bit is held, ≥1.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  payload word offered.
- in_data  input  DATA_W  payload word; sampled only on handshake.
- in_ready  output  1  transmitter idle and can accept; combinational, (state==IDLE) & ~rst.
- tx_bit  output  1  serial line; registered; 0 when idle.
- tx_active  output  1  registered; 1 while any frame bit (preamble through gap) is on the line.
- frame_done  output  1  registered; one-cycle pulse when a frame completes normally.

## Operation

- Handshake: accept when in_valid & in_ready at a rising edge. in_data is captured into a shift register, and even parity (XOR of all payload bits) is computed at capture.
- in_valid while in_ready=0 is ignored. in_data changes after capture have no effect.
- States:
  - IDLE: tx_bit=0.
  - PRE: 4 bits, 1,1,0,1.
  - DATA: DATA_W bits, in_data[DATA_W-1] first.
  - PAR: 1 bit, parity.
  - GAP: 1 bit, value 0.
- Transitions:
  - IDLE→PRE on handshake.
  - PRE→DATA after 4 bit periods.
  - DATA→PAR after DATA_W bit periods.
  - PAR→GAP after 1 bit period.
  - GAP→IDLE after 1 bit period.
- Counters:
  - Cycle counter 0..BIT_CYCLES-1 paces bit periods and wraps to 0 at each bit boundary.
  - Bit index counter sized for max(4, DATA_W) counts bits within PRE and DATA.
- The GAP bit guarantees that the detector sees a 0 after the parity bit, separating consecutive frames.
- Reset values: state IDLE, tx_bit 0, tx_active 0, frame_done 0, counters 0. in_ready is 0 while rst is high.
- Reset mid-frame: the frame is aborted. In the cycle after the reset edge, tx_bit=0 and tx_active=0. No frame_done is issued for the aborted frame, and its payload is discarded.
- If rst and handshake conditions coincide at an edge, rst wins and nothing is accepted.

## Timing

- Handshake at edge E0. Bit k of the frame (k=0..DATA_W+5) occupies cycles 1+k·BIT_CYCLES … (k+1)·BIT_CYCLES after E0.
- The first preamble bit appears on tx_bit in cycle 1; there is no extra latency.
- Frame length on the line: (DATA_W+6)·BIT_CYCLES cycles. With the defaults this is 14 cycles (cycles 1–14).
- tx_active=1 exactly over the frame cycles.
- frame_done=1 and in_ready=1 in cycle (DATA_W+6)·BIT_CYCLES+1, i.e. cycle 15 with the defaults.
- Back-to-back: the next handshake can occur at the end of that cycle. Minimum frame period is (DATA_W+6)·BIT_CYCLES+1 cycles, i.e. 15 with the defaults; between frames tx_bit=0 for that 1 IDLE cycle plus the GAP bit.
- in_ready is 0 from the cycle after E0 through the last GAP cycle.

## Test plan

- Reset: hold rst 3 cycles with in_valid=1 → in_ready=0, tx_bit=0, tx_active=0, frame_done=0. After release, in_ready=1 and no frame starts until a handshake at an edge with rst=0.
- Single frame, defaults, in_data=0xA5:
  - tx_bit over cycles 1–14 = 1,1,0,1, 1,0,1,0,0,1,0,1, 0 (parity), 0 (gap).
  - frame_done pulses in cycle 15.
- Back-to-back, in_valid held high, words 0xFF then 0x01:
  - Second preamble starts in cycle 16.
  - Parity bits are 0 then 1.
  - Exactly one 1-cycle frame_done per frame.
- BIT_CYCLES=3, DATA_W=8, in_data=0x80:
  - Each bit is held 3 cycles and the frame spans cycles 1–42.
  - DATA bits occupy cycles 13–36: 1 in cycles 13–15, 0 in cycles 16–36.
  - Parity 1 in cycles 37–39, gap 0 in cycles 40–42.
  - frame_done in cycle 43.
- Reset mid-frame: assert rst in cycle 7 of a frame → tx_bit=0 and tx_active=0 from cycle 8, no frame_done. A new handshake after release yields a complete, correct frame.
- Loopback into the 1101 non-overlapping detector, 10 frames of in_data=0x00:
  - Detector asserts detected exactly once per frame, in the cycle after the fourth preamble bit.
  - No other detections occur.
